// File: rtl/blackjack_pkg.sv
// Shared blackjack types and scoring helpers, used by card_dealer and the game FSM.
package blackjack_pkg;
  typedef logic [3:0] rank_t;

  typedef enum logic [2:0] {
    IDLE, SHUFFLE, READY, DEAL_READ, DEAL_ADD, DEAL_ACK
  } dealer_state_t;

  localparam logic [4:0] ACE_HI  = 5'd11;
  localparam logic [4:0] ACE_LO  = 5'd1;
  localparam logic [5:0] BUST    = 6'd21;
  localparam logic [5:0] PTS_MAX = 6'd63;

  function automatic logic [4:0] card_value(input rank_t r, input logic ace_high);
    if (r == 4'd1)      return ace_high ? ACE_HI : ACE_LO;
    else if (r > 4'd10) return 5'd10;
    else                return {1'b0, r};
  endfunction

  // Unshuffled deck: A..K repeated, four suits back to back.
  function automatic rank_t init_rank(input int k);
    return rank_t'((k % 13) + 1);
  endfunction
endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, advancing only while enabled.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] state
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       state <= SEED;
    else if (enable) state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
  end
endmodule

// File: rtl/card_dealer.sv
// Deck shuffle + card dealing + hand scoring engine for the blackjack FSM.
// Optional soft-ace demotion is enabled by defining CARD_SOFT_ACE_EN.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int          DECK_SIZE     = 52,
  parameter int          SHUFFLE_SWAPS = 104,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       embaralhar_start,
  input  logic       pjogador,
  input  logic       pdealer,
  output logic       embaralhar_ok,
  output logic       cartaok,
  output logic [5:0] pts_jogador,
  output logic [5:0] pts_dealer,
  output logic [3:0] carta,
  output logic       deck_empty
);
  localparam logic [15:0] SWAPS_L = 16'(SHUFFLE_SWAPS);
  localparam logic [5:0]  LAST    = 6'(DECK_SIZE - 1);

  dealer_state_t state;
  rank_t         deck [DECK_SIZE];
  logic [5:0]    ptr;
  logic [15:0]   swap_cnt;
  logic [15:0]   lfsr;
  logic          start_q, to_player;

  logic [5:0] idx_i, idx_j;
  logic       swap_ok, start_edge, restart, req_now;
  logic       unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .enable(state == SHUFFLE),
    .state (lfsr)
  );

  assign idx_i       = lfsr[5:0];
  assign idx_j       = lfsr[13:8];
  assign unused_lfsr = ^{lfsr[15:14], lfsr[7:6]};
  assign swap_ok     = (int'(idx_i) < DECK_SIZE) && (int'(idx_j) < DECK_SIZE);
  assign start_edge  = embaralhar_start && !start_q;
  assign restart     = start_edge && (state == IDLE || state == READY);
  assign req_now     = to_player ? pjogador : pdealer;

  // Next total for the latched hand: add, saturate, then optional ace demotion.
  logic [5:0] cur_pts, new_pts;
  logic [6:0] sum;
  logic [5:0] sat;
`ifdef CARD_SOFT_ACE_EN
  logic [2:0] soft_j, soft_d, cur_soft, new_soft;
`endif

  always_comb begin
    cur_pts = to_player ? pts_jogador : pts_dealer;
`ifdef CARD_SOFT_ACE_EN
    sum      = {1'b0, cur_pts} + {2'b0, card_value(carta, 1'b1)};
    sat      = (sum > 7'(PTS_MAX)) ? PTS_MAX : sum[5:0];
    cur_soft = to_player ? soft_j : soft_d;
    new_soft = cur_soft + ((carta == 4'd1) ? 3'd1 : 3'd0);
    new_pts  = sat;
    if (sat > BUST && new_soft != 3'd0) begin
      new_pts  = sat - 6'd10;
      new_soft = new_soft - 3'd1;
    end
`else
    sum     = {1'b0, cur_pts} + {2'b0, card_value(carta, 1'b0)};
    sat     = (sum > 7'(PTS_MAX)) ? PTS_MAX : sum[5:0];
    new_pts = sat;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      for (int k = 0; k < DECK_SIZE; k++) deck[k] <= init_rank(k);
      ptr           <= '0;
      swap_cnt      <= '0;
      start_q       <= 1'b0;
      to_player     <= 1'b0;
      embaralhar_ok <= 1'b0;
      cartaok       <= 1'b0;
      pts_jogador   <= '0;
      pts_dealer    <= '0;
      carta         <= '0;
      deck_empty    <= 1'b0;
`ifdef CARD_SOFT_ACE_EN
      soft_j        <= '0;
      soft_d        <= '0;
`endif
    end else begin
      start_q <= embaralhar_start;
      if (restart) begin
        for (int k = 0; k < DECK_SIZE; k++) deck[k] <= init_rank(k);
        ptr           <= '0;
        swap_cnt      <= '0;
        embaralhar_ok <= 1'b0;
        pts_jogador   <= '0;
        pts_dealer    <= '0;
        carta         <= '0;
        deck_empty    <= 1'b0;
`ifdef CARD_SOFT_ACE_EN
        soft_j        <= '0;
        soft_d        <= '0;
`endif
        state         <= SHUFFLE;
      end else begin
        case (state)
          IDLE: ;
          SHUFFLE: begin
            if (swap_cnt == SWAPS_L) begin
              embaralhar_ok <= 1'b1;
              state         <= READY;
            end else if (swap_ok) begin
              deck[idx_i] <= deck[idx_j];
              deck[idx_j] <= deck[idx_i];
              swap_cnt    <= swap_cnt + 16'd1;
            end
          end
          READY: begin
            if (pjogador || pdealer) begin
              to_player <= pjogador;
              state     <= DEAL_READ;
            end
          end
          DEAL_READ: begin
            carta <= deck[ptr];
            if (ptr == LAST) begin
              ptr        <= '0;
              deck_empty <= 1'b1;
            end else begin
              ptr <= ptr + 6'd1;
            end
            state <= DEAL_ADD;
          end
          DEAL_ADD: begin
            if (to_player) pts_jogador <= new_pts;
            else           pts_dealer  <= new_pts;
`ifdef CARD_SOFT_ACE_EN
            if (to_player) soft_j <= new_soft;
            else           soft_d <= new_soft;
`endif
            state <= DEAL_ACK;
          end
          DEAL_ACK: begin
            if (!req_now) begin
              cartaok <= 1'b0;
              state   <= READY;
            end else begin
              cartaok <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: u0 has an unshuffled deck, u1 uses default shuffling.
module tb_card_dealer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0]      start = '0, pj = '0, pd = '0;
  logic [1:0]      ok, cok, empty;
  logic [1:0][5:0] ptsj, ptsd;
  logic [1:0][3:0] carta;

  int checks = 0;
  int errors = 0;

`ifdef CARD_SOFT_ACE_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  typedef struct {
    bit known;
    int card;
    int pj;
    int pd;
  } exp_t;
  exp_t sb[$];

  // u0 reference model
  int mptr = 0, mpj = 0, mpd = 0, msj = 0, msd = 0;

  always #5 clock = ~clock;

  card_dealer #(.SHUFFLE_SWAPS(0)) u0 (
    .clock(clock), .reset(reset), .embaralhar_start(start[0]),
    .pjogador(pj[0]), .pdealer(pd[0]), .embaralhar_ok(ok[0]), .cartaok(cok[0]),
    .pts_jogador(ptsj[0]), .pts_dealer(ptsd[0]), .carta(carta[0]), .deck_empty(empty[0])
  );

  card_dealer u1 (
    .clock(clock), .reset(reset), .embaralhar_start(start[1]),
    .pjogador(pj[1]), .pdealer(pd[1]), .embaralhar_ok(ok[1]), .cartaok(cok[1]),
    .pts_jogador(ptsj[1]), .pts_dealer(ptsd[1]), .carta(carta[1]), .deck_empty(empty[1])
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic madd(inout int tot, inout int sc, input int r);
    int v;
    v = (r == 1) ? (SOFT ? 11 : 1) : (r > 10 ? 10 : r);
    tot = tot + v;
    if (tot > 63) tot = 63;
    if (SOFT && r == 1) sc++;
    if (tot > 21 && sc > 0) begin
      tot = tot - 10;
      sc--;
    end
  endtask

  task automatic mclear();
    mptr = 0; mpj = 0; mpd = 0; msj = 0; msd = 0;
  endtask

  task automatic chk_zero(input int u, input string tag);
    chk({tag, "_ok"}, ok[u], 0);
    chk({tag, "_cok"}, cok[u], 0);
    chk({tag, "_pj"}, ptsj[u], 0);
    chk({tag, "_pd"}, ptsd[u], 0);
    chk({tag, "_carta"}, carta[u], 0);
    chk({tag, "_empty"}, empty[u], 0);
  endtask

  task automatic shuffle(input int u, input int budget, output int n, output int first_ok);
    @(negedge clock);
    start[u] = 1'b1;
    n = 0;
    first_ok = -1;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) first_ok = ok[u];
    end while (!ok[u] && n < budget);
    start[u] = 1'b0;
    chk("shuf_done", ok[u], 1);
    if (u == 0) mclear();
  endtask

  task automatic deal(input int u, input bit pl, input bit dl, input int hold, output int got);
    exp_t e;
    int n, r;
    @(negedge clock);
    pj[u] = pl;
    pd[u] = dl;
    e.known = (u == 0);
    e.card = 0; e.pj = 0; e.pd = 0;
    if (u == 0) begin
      r = (mptr % 13) + 1;
      mptr = (mptr == 51) ? 0 : mptr + 1;
      if (pl) madd(mpj, msj, r);
      else    madd(mpd, msd, r);
      e.card = r; e.pj = mpj; e.pd = mpd;
    end
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!cok[u] && n < 20);
    chk("ack_lat", n, 4);
    e = sb.pop_front();
    got = carta[u];
    if (e.known) begin
      chk("card", carta[u], e.card);
      chk("pts_j", ptsj[u], e.pj);
      chk("pts_d", ptsd[u], e.pd);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk("hold_cok", cok[u], 1);
      chk("hold_card", carta[u], got);
    end
    pj[u] = 1'b0;
    pd[u] = 1'b0;
    @(negedge clock);
    chk("ack_low", cok[u], 0);
  endtask

  initial begin
    int n, fo, got, c1, same;
    int tbl[5];
    int cnt[13];

    #1;
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Requests before any shuffle are ignored
    pj[0] = 1'b1;
    repeat (6) @(negedge clock);
    chk("idle_ign_cok", cok[0], 0);
    chk("idle_ign_carta", carta[0], 0);
    pj[0] = 1'b0;

    shuffle(0, 10, n, fo);
    chk("noswap_lat", (n >= 2 && n <= 3) ? 1 : 0, 1);

    // Ordered deck: A..5 to player, hold first request to prove a single deal
    if (SOFT) tbl = '{11, 13, 16, 20, 15};
    else      tbl = '{1, 3, 6, 10, 15};
    for (int k = 0; k < 5; k++) begin
      deal(0, 1'b1, 1'b0, (k == 0) ? 4 : 0, got);
      chk("soft_tbl", ptsj[0], tbl[k]);
    end

    // Restart from READY clears totals, then saturate the dealer
    shuffle(0, 10, n, fo);
    chk("restart_ok_drop", fo, 0);
    chk("restart_pj", ptsj[0], 0);
    chk("restart_empty", empty[0], 0);
    for (int k = 0; k < 13; k++) deal(0, 1'b0, 1'b1, 0, got);
    chk("sat_dealer", ptsd[0], 63);
    deal(0, 1'b1, 1'b1, 0, got);
    chk("prio_dealer", ptsd[0], 63);
    chk("prio_player", ptsj[0], SOFT ? 11 : 1);

    // Shuffled deck integrity
    shuffle(1, 5000, n, fo);
    for (int r = 0; r < 13; r++) cnt[r] = 0;
    c1 = 0;
    same = 0;
    for (int k = 1; k <= 53; k++) begin
      deal(1, (k % 2) == 1, (k % 2) == 0, 0, got);
      chk("empty_flag", empty[1], (k >= 52) ? 1 : 0);
      if (k == 1) c1 = got;
      if (k <= 52) begin
        chk("rank_range", (got >= 1 && got <= 13) ? 1 : 0, 1);
        if (got >= 1 && got <= 13) cnt[got-1]++;
        if (got == ((k - 1) % 13) + 1) same++;
      end else begin
        chk("wrap_card", got, c1);
      end
    end
    for (int r = 0; r < 13; r++) chk($sformatf("rank%0d_cnt", r + 1), cnt[r], 4);
    chk("shuffled", (same < 52) ? 1 : 0, 1);

    // Reset in the middle of DEAL_ACK
    @(negedge clock);
    pj[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!cok[0] && n < 20);
    chk("pre_rst_cok", cok[0], 1);
    reset = 1'b1;
    #1;
    chk_zero(0, "midrst0");
    chk("midrst1_empty", empty[1], 0);
    pj[0] = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    shuffle(0, 10, n, fo);
    deal(0, 1'b1, 1'b0, 0, got);
    chk("post_rst_card", got, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
